// File: rtl/mem_arbiter.sv
// Round-robin arbiter for one shared memory between the CPU port and the DMA/IO port.
// Each grant runs a fixed-latency access and returns a one-cycle ack with registered read data.
module mem_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  output logic          o_c_ack,
  output logic [DW-1:0] o_c_rdata,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_ack,
  output logic [DW-1:0] o_d_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_mem_read,
  output logic          o_mem_write,
  output logic          o_busy,
  output logic          o_owner
);

  // state  | meaning
  // IDLE   | waiting for a request; arbitrate and latch the winner's command
  // ACCESS | memory strobes active for WAIT_CYCLES cycles
  // DONE   | one-cycle ack to the owner
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t        r_state, w_state_nxt;
  logic          r_last, r_owner, r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [3:0]    r_cnt;
  logic          w_grant, w_sel_dma;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    // On a tie the port that was not served last wins.
    w_sel_dma   = i_d_req & ~(i_c_req & r_last);
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_c_ack     = 1'b0;
    o_d_ack     = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_c_req || i_d_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        o_mem_read  = ~r_we;
        o_mem_write = r_we;
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_c_ack     = ~r_owner;
        o_d_ack     = r_owner;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= 4'd0;
    end else if (w_grant) begin
      r_owner <= w_sel_dma;
      r_we    <= w_sel_dma ? i_d_we    : i_c_we;
      r_addr  <= w_sel_dma ? i_d_addr  : i_c_addr;
      r_wdata <= w_sel_dma ? i_d_wdata : i_c_wdata;
      r_cnt   <= CNT_INIT;
    end else if (r_state == S_ACCESS) begin
      if (r_cnt == 4'd0) begin
        r_last <= r_owner;
        if (!r_we) r_rdata <= i_mem_rdata;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_c_rdata   = r_rdata;
  assign o_d_rdata   = r_rdata;
  assign o_owner     = r_owner;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the processor's single shared memory. It sits between the memory and two masters: the multi-cycle CPU controller/datapath port (instruction fetch and data load/store, selected upstream by IorD) and a DMA/IO port used to preload or inspect memory. It grants the memory round-robin, sequences a fixed-latency access, and returns a one-cycle acknowledge with read data to the owner.

## Interface
- AW, 8: address width.
- DW, 8: data width.
- WAIT_CYCLES, 1: memory access cycles per transfer. Legal range is 1..15.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- c_req  in  1  CPU request.
- c_we  in  1  CPU write (1) / read (0).
- c_addr  in  AW  CPU address.
- c_wdata  in  DW  CPU write data.
- c_ack  out  1  CPU transfer complete, one-cycle pulse.
- c_rdata  out  DW  read data, valid while c_ack=1.
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  DMA port, same meaning as the CPU port.
- d_ack  out  1  DMA transfer complete, one-cycle pulse.
- d_rdata  out  DW  read data, valid while d_ack=1.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- busy  out  1  high in every state except IDLE.
- owner  out  1  0 = CPU, 1 = DMA; the current or most recent grant.

## Operation
- The FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the port that was not served last.
  - `last` resets to DMA, so the CPU wins the first tie after reset.
  - On a grant, latch we/addr/wdata from the granted port into internal registers, set owner, load cnt=WAIT_CYCLES-1, and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_read = ~we and mem_write = we, both asserted for every ACCESS cycle.
  - cnt decrements each cycle.
  - In the cycle where cnt==0, capture mem_rdata into rdata (reads only), set last=owner, and go to DONE.
- DONE:
  - Pulse the owner's ack for one cycle, then go to IDLE.
  - c_rdata and d_rdata both show the rdata register. The value is meaningful only when the matching ack is high.
  - A write leaves rdata unchanged.
- Requester rules:
  - A requester holds req and its signals stable until its ack.
  - Port inputs are sampled only at grant. Changes after the grant are ignored.
  - A request dropped after grant still completes: the memory access happens and ack still pulses.
- Req still high during the DONE cycle is not a new request. IDLE re-samples it on the next cycle.
- Outputs outside ACCESS: mem_read=mem_write=0; mem_addr and mem_wdata hold the latched values.
- Fairness: with both ports requesting continuously, grants strictly alternate.

## Timing
- Reset values: c_ack=d_ack=0, c_rdata=d_rdata=0, mem_addr=0, mem_wdata=0, mem_read=mem_write=0, busy=0, owner=0, state=IDLE, last=1, cnt=0.
- rst low forces these values immediately, independent of clk.
- Reset during ACCESS aborts the transfer: strobes drop at once and no ack is issued.
- Transfer latency: a request first seen in IDLE at edge N gives ACCESS at cycles N+1..N+WAIT_CYCLES and ack at cycle N+WAIT_CYCLES+1.
- Back-to-back throughput: WAIT_CYCLES+2 cycles per transfer (IDLE, ACCESS×WAIT_CYCLES, DONE).
- The memory must present mem_rdata by the last ACCESS cycle. No combinational path from mem_rdata to c_rdata/d_rdata.
- busy is high from the first ACCESS cycle through DONE.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs 0. Release with no requests -> IDLE, busy=0, no strobes.
- CPU read, WAIT_CYCLES=1: c_req=1, c_we=0, c_addr=0x12, memory returns 0xA5 -> mem_read=1 for exactly one cycle with mem_addr=0x12; c_ack pulses one cycle later with c_rdata=0xA5; d_ack stays 0.
- Tie after reset: c_req and d_req rise together (CPU read 0x10, DMA write 0x3C to 0x20) -> CPU served first (owner=0), then DMA (owner=1). mem_write=1 with mem_addr=0x20 and mem_wdata=0x3C. Acks are 3 cycles apart.
- Fairness: both requests held high for 6 transfers -> owner sequence 0,1,0,1,0,1. Every ack goes only to the matching port.
- WAIT_CYCLES=3: DMA read 0x7F, memory returns 0x5A only in the third ACCESS cycle -> mem_read high 3 cycles; d_ack in the 4th cycle after grant with d_rdata=0x5A.
- Reset mid-op: assert rst=0 in the second ACCESS cycle of a CPU write -> mem_write drops asynchronously and no c_ack. After release with both requests high, CPU is granted first.
